// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// ----------------
// Shares one split-strobe RAM between two requesters. Port 0 is the processor
// core and port 1 is the program loader / debug access. The arbiter grants one
// request at a time, drives the RAM strobe sequence (strobe low for one cycle,
// high for one cycle, then capture) and returns a one-cycle acknowledge.
//
// Request/acknowledge handshake:
//   A requester raises req_p with we_p/addr_p/wdata_p valid. The arbiter samples
//   them on the grant edge; after that the requester inputs are don't-care.
//   Completion is a single-cycle ack_p pulse. A port whose ack_p is high is not
//   eligible in that cycle, so a requester that drops req_p on seeing ack_p is
//   never granted a second time by mistake. rdata_p is valid from ack_p and held
//   until that port's next read completes.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   req0/1, we0/1           request and write-enable (1 = write) per port
//   addr0/1, wdata0/1       access address and write data per port
//   ack0/1, rdata0/1        completion pulse and read result per port
//   hold0                   blocks new grants to port 0 (loader owns RAM)
//   busy                    high whenever an access is in flight
//   grant                   port currently or most recently served
//   read_from, write_into   RAM read / write addresses
//   write                   RAM write data
//   read_clock, write_clock RAM read / write strobes, idle high
//   read                    RAM read data (q)
//   state_dbg               current state encoding, for observation only
//
// All outputs are registered.

module ram_port_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,

  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [WORD_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [WORD_WIDTH-1:0] rdata0,
  input  logic                  hold0,

  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [WORD_WIDTH-1:0] rdata1,

  output logic                  busy,
  output logic                  grant,

  output logic [ADDR_WIDTH-1:0] read_from,
  output logic [ADDR_WIDTH-1:0] write_into,
  output logic [WORD_WIDTH-1:0] write,
  output logic                  read_clock,
  output logic                  write_clock,
  input  logic [WORD_WIDTH-1:0] read,

  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    RD_CAP = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5
  } state_t;

  state_t state_q;
  state_t state_n;

  // Next values of the registered outputs.
  logic                  grant_n;
  logic                  busy_n;
  logic [ADDR_WIDTH-1:0] read_from_n;
  logic [ADDR_WIDTH-1:0] write_into_n;
  logic [WORD_WIDTH-1:0] write_n;
  logic                  read_clock_n;
  logic                  write_clock_n;
  logic                  ack0_n;
  logic                  ack1_n;
  logic [WORD_WIDTH-1:0] rdata0_n;
  logic [WORD_WIDTH-1:0] rdata1_n;

  // Eligibility: a port whose ack is still high is in the cycle where its
  // requester is dropping req, so it must not be granted again.
  logic                  elig0;
  logic                  elig1;
  logic                  pick;
  logic                  pick_we;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [WORD_WIDTH-1:0] pick_wdata;

  assign elig0 = req0 & ~ack0 & ~hold0;
  assign elig1 = req1 & ~ack1;

  // Both eligible: serve the port that was not served last (round-robin).
  // Only one eligible: serve that one (elig1 selects port 1 directly).
  assign pick       = (elig0 & elig1) ? ~grant : elig1;
  assign pick_we    = pick ? we1    : we0;
  assign pick_addr  = pick ? addr1  : addr0;
  assign pick_wdata = pick ? wdata1 : wdata0;

  assign state_dbg = state_q;

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state_q;
    grant_n       = grant;
    busy_n        = busy;
    read_from_n   = read_from;
    write_into_n  = write_into;
    write_n       = write;
    read_clock_n  = read_clock;
    write_clock_n = write_clock;
    ack0_n        = 1'b0;   // ack is a single-cycle pulse
    ack1_n        = 1'b0;
    rdata0_n      = rdata0;
    rdata1_n      = rdata1;

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          grant_n = pick;
          busy_n  = 1'b1;
          if (pick_we) begin
            write_into_n = pick_addr;
            write_n      = pick_wdata;
            state_n      = WR_LO;
          end else begin
            read_from_n = pick_addr;
            state_n     = RD_LO;
          end
        end
      end

      RD_LO: begin
        read_clock_n = 1'b0;
        state_n      = RD_HI;
      end

      RD_HI: begin
        // Rising read strobe: RAM presents q for capture on the next edge.
        read_clock_n = 1'b1;
        state_n      = RD_CAP;
      end

      RD_CAP: begin
        if (grant) begin
          rdata1_n = read;
          ack1_n   = 1'b1;
        end else begin
          rdata0_n = read;
          ack0_n   = 1'b1;
        end
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      WR_LO: begin
        write_clock_n = 1'b0;
        state_n       = WR_HI;
      end

      WR_HI: begin
        // Rising write strobe commits the latched address/data.
        write_clock_n = 1'b1;
        if (grant) begin
          ack1_n = 1'b1;
        end else begin
          ack0_n = 1'b1;
        end
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        read_clock_n  = 1'b1;
        write_clock_n = 1'b1;
        busy_n        = 1'b0;
        state_n       = IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any access without an ack.
  // Forcing write_clock high during WR_HI is a rising strobe edge, so a write
  // interrupted there still lands in the RAM; an interrupted read is harmless.
  // grant resets to 1 so that port 0 wins the first contention.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant       <= 1'b1;
      busy        <= 1'b0;
      read_from   <= '0;
      write_into  <= '0;
      write       <= '0;
      read_clock  <= 1'b1;
      write_clock <= 1'b1;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      state_q     <= state_n;
      grant       <= grant_n;
      busy        <= busy_n;
      read_from   <= read_from_n;
      write_into  <= write_into_n;
      write       <= write_n;
      read_clock  <= read_clock_n;
      write_clock <= write_clock_n;
      ack0        <= ack0_n;
      ack1        <= ack1_n;
      rdata0      <= rdata0_n;
      rdata1      <= rdata1_n;
    end
  end

endmodule
